// File: rtl/pipeexe_md.sv
// pipeexe_md: EXE stage of the pipelined MIPS core -- combinational ALU/JAL result path
// plus a background iterative multiply/divide unit that owns the HI/LO registers.
module pipeexe_md #(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic            evalid,
  input  logic [3:0]      ealuc,
  input  logic            ealuimm,
  input  logic            eshift,
  input  logic            ejal,
  input  logic [2:0]      emdop,
  input  logic [XLEN-1:0] ea,
  input  logic [XLEN-1:0] eb,
  input  logic [XLEN-1:0] eimm,
  input  logic [XLEN-1:0] epc4,
  input  logic [4:0]      ern0,
  output logic [XLEN-1:0] ealu,
  output logic [4:0]      ern,
  output logic            estall,
  output logic            ebusy,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);
  localparam int SW = $clog2(XLEN);
  localparam int CW = SW + 1;

  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MFHI  = 3'd5;
  localparam logic [2:0] MD_MFLO  = 3'd6;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt;
  logic              op_div, sgn_a, sgn_b;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [2*XLEN-1:0] acc;

  logic md_op, hilo_rd, issue, done;

  assign md_op   = (emdop >= MD_MULT) && (emdop <= MD_DIVU);
  assign hilo_rd = (emdop == MD_MFHI) || (emdop == MD_MFLO);
  assign issue   = (state == IDLE) && evalid && md_op;
  assign done    = (state == BUSY) && (cnt == CW'(1));

  // ---------------- ALU path ----------------
  logic [XLEN-1:0] imm_sh, sa, alu_a, alu_b, alu_r;
  logic [SW-1:0]   shamt;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    imm_sh = eimm >> 6;
    sa     = imm_sh & XLEN'(31);
    alu_a  = eshift ? sa : ea;
    alu_b  = ealuimm ? eimm : eb;
    shamt  = alu_a[SW-1:0];
  end

  // Shifts and LUI operate on B; A supplies the shift amount.
  always_comb begin
    alu_r = alu_a + alu_b;
    casez (ealuc)
      4'b?000: alu_r = alu_a + alu_b;
      4'b?100: alu_r = alu_a - alu_b;
      4'b?001: alu_r = alu_a & alu_b;
      4'b?101: alu_r = alu_a | alu_b;
      4'b?010: alu_r = alu_a ^ alu_b;
      4'b?110: alu_r = alu_b << (XLEN / 2);
      4'b0011: alu_r = alu_b << shamt;
      4'b0111: alu_r = alu_b >> shamt;
      4'b1111: alu_r = $signed(alu_b) >>> shamt;
      default: alu_r = alu_a + alu_b;
    endcase
  end

  always_comb begin
    if (ejal)                   ealu = epc4 + XLEN'(4);
    else if (emdop == MD_MFHI)  ealu = hi;
    else if (emdop == MD_MFLO)  ealu = lo;
    else                        ealu = alu_r;
  end

  always_comb begin
    if (ejal)       ern = 5'd31;
    else if (md_op) ern = 5'd0;
    else            ern = ern0;
  end

  // ---------------- mul/div control FSM ----------------
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (issue) state_nxt = BUSY;
      BUSY:    if (done)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ebusy  = (state == BUSY);
    estall = evalid && (state == BUSY) && (md_op || hilo_rd);
  end

  // ---------------- operand capture ----------------
  logic            op_signed, op_is_div, sgn_a_in, sgn_b_in;
  logic [XLEN-1:0] mag_a_in, mag_b_in;

  always_comb begin
    op_signed = (emdop == MD_MULT) || (emdop == MD_DIV);
    op_is_div = (emdop == MD_DIV) || (emdop == MD_DIVU);
    sgn_a_in  = op_signed & ea[XLEN-1];
    sgn_b_in  = op_signed & eb[XLEN-1];
    mag_a_in  = sgn_a_in ? -ea : ea;
    mag_b_in  = sgn_b_in ? -eb : eb;
  end

  // ---------------- one iteration + final sign fix ----------------
  // Multiply: acc = {partial, multiplier}, shift right. Divide: acc = {remainder, dividend/quotient}.
  logic [XLEN:0]     mul_sum, div_r, div_diff;
  logic [2*XLEN-1:0] acc_nxt, prod;
  logic [XLEN-1:0]   q_mag, r_mag, res_hi, res_lo;

  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mag_a} : '0);
    div_r    = acc[2*XLEN-1:XLEN-1];
    div_diff = div_r - {1'b0, mag_b};
    if (!op_div)
      acc_nxt = {mul_sum, acc[XLEN-1:1]};
    else if (!div_diff[XLEN])
      acc_nxt = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    else
      acc_nxt = {div_r[XLEN-1:0], acc[XLEN-2:0], 1'b0};

    q_mag  = acc_nxt[XLEN-1:0];
    r_mag  = acc_nxt[2*XLEN-1:XLEN];
    prod   = (sgn_a ^ sgn_b) ? -acc_nxt : acc_nxt;
    res_hi = prod[2*XLEN-1:XLEN];
    res_lo = prod[XLEN-1:0];
    if (op_div) begin
      if (mag_b == '0) begin
        // Divide by zero returns the dividend exactly as it was presented.
        res_lo = '1;
        res_hi = sgn_a ? -mag_a : mag_a;
      end else begin
        res_lo = (sgn_a ^ sgn_b) ? -q_mag : q_mag;
        res_hi = sgn_a ? -r_mag : r_mag;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt    <= '0;
      op_div <= 1'b0;
      sgn_a  <= 1'b0;
      sgn_b  <= 1'b0;
      mag_a  <= '0;
      mag_b  <= '0;
      acc    <= '0;
      hi     <= '0;
      lo     <= '0;
    end else if (issue) begin
      cnt    <= CW'(XLEN);
      op_div <= op_is_div;
      sgn_a  <= sgn_a_in;
      sgn_b  <= sgn_b_in;
      mag_a  <= mag_a_in;
      mag_b  <= mag_b_in;
      acc    <= {{XLEN{1'b0}}, (op_is_div ? mag_a_in : mag_b_in)};
    end else if (state == BUSY) begin
      cnt <= cnt - CW'(1);
      acc <= acc_nxt;
      if (done) begin
        hi <= res_hi;
        lo <= res_lo;
      end
    end
  end

endmodule

// File: tb/tb_pipeexe_md.sv
// Directed bench for pipeexe_md: ALU/JAL path, mul/div results, stall timing and reset,
// on a 32-bit instance plus one 16-bit multiply.
module tb_pipeexe_md;
  localparam logic [2:0] NOP = 3'd0, MULT = 3'd1, MULTU = 3'd2, DIV = 3'd3, DIVU = 3'd4,
                         MFHI = 3'd5, MFLO = 3'd6;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        resetn;
  logic        evalid, ealuimm, eshift, ejal, estall, ebusy;
  logic [3:0]  ealuc;
  logic [2:0]  emdop;
  logic [31:0] ea, eb, eimm, epc4, ealu, hi, lo;
  logic [4:0]  ern0, ern;

  logic        evalid16, estall16, ebusy16;
  logic [2:0]  emdop16;
  logic [15:0] ea16, eb16, ealu16, hi16, lo16;
  logic [4:0]  ern16;

  pipeexe_md #(.XLEN(32)) dut (
    .clock(clock), .resetn(resetn), .evalid(evalid), .ealuc(ealuc), .ealuimm(ealuimm),
    .eshift(eshift), .ejal(ejal), .emdop(emdop), .ea(ea), .eb(eb), .eimm(eimm), .epc4(epc4),
    .ern0(ern0), .ealu(ealu), .ern(ern), .estall(estall), .ebusy(ebusy), .hi(hi), .lo(lo)
  );

  pipeexe_md #(.XLEN(16)) dut16 (
    .clock(clock), .resetn(resetn), .evalid(evalid16), .ealuc(4'd0), .ealuimm(1'b0),
    .eshift(1'b0), .ejal(1'b0), .emdop(emdop16), .ea(ea16), .eb(eb16), .eimm(16'd0),
    .epc4(16'd0), .ern0(5'd3), .ealu(ealu16), .ern(ern16), .estall(estall16),
    .ebusy(ebusy16), .hi(hi16), .lo(lo16)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    evalid = 1'b1; emdop = op; ea = a; eb = b; ealuc = 4'd0; ealuimm = 1'b0;
    eshift = 1'b0; ejal = 1'b0; eimm = '0; epc4 = '0; ern0 = 5'd9;
    #1;
  endtask

  // From cycle 1 of an operation: feed NOPs until the unit goes idle, return busy cycles.
  task automatic wait_idle(output int n);
    n = 0;
    drive(NOP, 0, 0);
    while (ebusy && n < 100) begin
      n++;
      tick();
      drive(NOP, 0, 0);
    end
  endtask

  typedef struct {
    logic [3:0]  c;
    logic        ui, sh;
    logic [31:0] a, b, imm, exp;
  } alu_vec_t;

  alu_vec_t alu_tab [10] = '{
    '{4'b0000, 1'b0, 1'b0, 32'h0000_0005, 32'h0000_0003, 32'h0,         32'h0000_0008},
    '{4'b0100, 1'b0, 1'b0, 32'h0000_0005, 32'h0000_0007, 32'h0,         32'hFFFF_FFFE},
    '{4'b0001, 1'b0, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0,         32'hF000_F000},
    '{4'b0101, 1'b0, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0,         32'hFFF0_FFF0},
    '{4'b0010, 1'b0, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0,         32'h0FF0_0FF0},
    '{4'b0110, 1'b1, 1'b0, 32'h0,         32'h0,         32'h0000_1234, 32'h1234_0000},
    '{4'b0000, 1'b1, 1'b0, 32'h0000_0010, 32'h0,         32'hFFFF_FFFF, 32'h0000_000F},
    '{4'b0011, 1'b0, 1'b1, 32'h0,         32'h0000_000F, 32'h0000_0100, 32'h0000_00F0},
    '{4'b0111, 1'b0, 1'b1, 32'h0,         32'h8000_0000, 32'hFFFF_0100, 32'h0800_0000},
    '{4'b1111, 1'b0, 1'b1, 32'h0,         32'h8000_0000, 32'h0000_07C0, 32'hFFFF_FFFF}
  };

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    resetn = 1'b0;
    evalid16 = 1'b0; emdop16 = NOP; ea16 = '0; eb16 = '0;
    drive(MFHI, 0, 0);
    #10;
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_busy", ebusy, 0);
    check("rst_stall", estall, 0);
    resetn = 1'b1;
    tick();

    // mult -3 * 5 with ALU and JAL traffic flowing underneath
    drive(MULT, 32'hFFFF_FFFD, 32'h0000_0005);
    check("mult_issue_ern", ern, 0);
    check("mult_issue_stall", estall, 0);
    for (int cyc = 1; cyc <= 33; cyc++) begin
      tick();
      if (cyc <= 10) begin
        drive(NOP, alu_tab[cyc-1].a, alu_tab[cyc-1].b);
        ealuc = alu_tab[cyc-1].c; ealuimm = alu_tab[cyc-1].ui;
        eshift = alu_tab[cyc-1].sh; eimm = alu_tab[cyc-1].imm;
        #1;
        check($sformatf("alu%0d", cyc - 1), ealu, alu_tab[cyc-1].exp);
        check($sformatf("alu%0d_ern", cyc - 1), ern, 5'd9);
      end else if (cyc == 11) begin
        drive(NOP, 0, 0);
        ejal = 1'b1; epc4 = 32'h0040_0010; ern0 = 5'd0;
        #1;
        check("jal_ealu", ealu, 32'h0040_0014);
        check("jal_ern", ern, 5'd31);
        check("jal_stall", estall, 0);
      end else begin
        drive(NOP, 0, 0);
      end
      if (cyc == 1 || cyc == 32) check($sformatf("mult_busy_c%0d", cyc), ebusy, 1);
      if (cyc == 32) check("mult_hi_stale", {hi, lo}, 64'h0);
      if (cyc == 33) begin
        check("mult_done_busy", ebusy, 0);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFF1);
      end
    end

    // multu then mfhi in the very next cycle
    tick();
    drive(MULTU, 32'hFFFF_FFFF, 32'h0000_0002);
    tick();
    drive(MFHI, 0, 0);
    n = 0;
    while (estall && n < 100) begin
      n++;
      tick();
    end
    check("mfhi_stall_cycles", n, 32);
    check("mfhi_ealu", ealu, 32'h0000_0001);
    check("mfhi_ern", ern, 5'd9);
    tick();
    drive(MFLO, 0, 0);
    check("mflo_ealu", ealu, 32'hFFFF_FFFE);
    check("mflo_stall", estall, 0);

    // div -7/2 followed back-to-back by divu 7/0
    tick();
    drive(DIV, 32'hFFFF_FFF9, 32'h0000_0002);
    tick();
    drive(DIVU, 32'h0000_0007, 32'h0000_0000);
    check("b2b_stall_c1", estall, 1);
    n = 0;
    while (estall && n < 100) begin
      n++;
      tick();
    end
    check("b2b_stall_cycles", n, 32);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);
    tick();
    wait_idle(n);
    check("divu0_cycles", n, 32);
    check("divu0_lo", lo, 32'hFFFF_FFFF);
    check("divu0_hi", hi, 32'h0000_0007);

    drive(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    tick();
    wait_idle(n);
    check("divmin_lo", lo, 32'h8000_0000);
    check("divmin_hi", hi, 32'h0000_0000);

    drive(DIV, 32'h0000_0007, 32'hFFFF_FFFE);
    tick();
    wait_idle(n);
    check("divneg_lo", lo, 32'hFFFF_FFFD);
    check("divneg_hi", hi, 32'h0000_0001);

    drive(DIVU, 32'h0000_0064, 32'h0000_0007);
    tick();
    wait_idle(n);
    check("divu_lo", lo, 32'h0000_000E);
    check("divu_hi", hi, 32'h0000_0002);

    // reset in the middle of a multiply
    drive(MULT, 32'h0000_0006, 32'h0000_0007);
    for (int i = 0; i < 10; i++) begin
      tick();
      drive(NOP, 0, 0);
    end
    drive(MFHI, 0, 0);
    check("pre_rst_stall", estall, 1);
    resetn = 1'b0;
    #1;
    check("midrst_hi", hi, 0);
    check("midrst_lo", lo, 0);
    check("midrst_busy", ebusy, 0);
    check("midrst_stall", estall, 0);
    #2;
    resetn = 1'b1;
    tick();
    drive(MFHI, 0, 0);
    check("postrst_stall", estall, 0);
    check("postrst_ealu", ealu, 0);
    check("postrst_busy", ebusy, 0);

    // 16-bit instance: 0x8000 * 0x8000 signed
    drive(NOP, 0, 0);
    evalid16 = 1'b1; emdop16 = MULT; ea16 = 16'h8000; eb16 = 16'h8000;
    tick();
    emdop16 = NOP;
    n = 0;
    while (ebusy16 && n < 100) begin
      n++;
      tick();
    end
    check("m16_cycles", n, 16);
    check("m16_hi", hi16, 16'h4000);
    check("m16_lo", lo16, 16'h0000);
    emdop16 = MFHI;
    #1;
    check("m16_mfhi", ealu16, 16'h4000);
    check("m16_ern", ern16, 5'd3);
    check("m16_stall", estall16, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
